// File: rtl/cmp_scheduler_pkg.sv
// Shared constants and FSM encoding for the comparator scheduler.
// Hash-list geometry matches the comparator instance this block feeds.
package cmp_scheduler_pkg;

  localparam int NUM_HASHES     = 8;
  localparam int HASH_NUM_MSB   = 2;
  localparam int HASH_COUNT_MSB = 3;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_START = 3'd2,
    ST_BLANK = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/cmp_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after i_ptr, wrapping mod N_REQ.
// Zero latency; no flow control of its own, the caller decides when to consume the pick.
module cmp_scheduler_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ID_MSB = $clog2(N_REQ) - 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_MSB:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_MSB:0]  o_idx,
  output logic             o_any
);

  localparam int PW = ID_MSB + 2;

  logic [PW-1:0]   v_sum;
  logic [ID_MSB:0] v_idx;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    v_sum = '0;
    v_idx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      // one extra bit holds ptr+off before the modulo fold
      v_sum = {1'b0, i_ptr} + PW'(off);
      if (v_sum >= PW'(N_REQ)) begin
        v_sum = v_sum - PW'(N_REQ);
      end
      v_idx = v_sum[ID_MSB:0];
      if (!o_any && i_req[v_idx]) begin
        o_any        = 1'b1;
        o_gnt[v_idx] = 1'b1;
        o_idx        = v_idx;
      end
    end
  end

endmodule

// File: rtl/cmp_scheduler.sv
// Shares one comparator among N_REQ requesters: gnt 1 cycle after req, cmp_start 1 after gnt, flags sampled 3 after start.
// Result is held on resp_* until resp_ready; no new grant while busy or cfg_lock is high.
module cmp_scheduler
  import cmp_scheduler_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int ID_MSB       = $clog2(N_REQ) - 1,
  parameter int FLUSH_CYCLES = NUM_HASHES + 4
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*32-1:0]     req_data,
  output logic [N_REQ-1:0]        gnt,
  input  logic                    cfg_lock,
  input  logic [HASH_COUNT_MSB:0] hash_count,
  output logic [31:0]             cmp_data,
  output logic                    cmp_start,
  input  logic                    cmp_found,
  input  logic                    cmp_finished,
  input  logic [HASH_NUM_MSB:0]   cmp_hash_num,
  output logic                    busy,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_MSB:0]         resp_id,
  output logic                    resp_found,
  output logic [HASH_NUM_MSB:0]   resp_hash_num
);

  localparam int              FW         = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0]   FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [ID_MSB:0] LAST_ID    = (ID_MSB + 1)'(N_REQ - 1);

  state_t                r_state;
  logic [FW-1:0]         r_flush_cnt;
  logic                  r_blank_cnt;
  logic [ID_MSB:0]       r_rr_ptr;
  logic [N_REQ-1:0]      r_gnt;
  logic                  r_cmp_start;
  logic                  r_busy;
  logic                  r_resp_valid;
  logic [ID_MSB:0]       r_resp_id;
  logic                  r_resp_found;
  logic [HASH_NUM_MSB:0] r_resp_hash_num;
  logic [31:0]           r_cmp_data;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_MSB:0]  w_idx;
  logic             w_any;
  logic [31:0]      w_req_word [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_word
    assign w_req_word[gi] = req_data[32*gi +: 32];
  end

  cmp_scheduler_rr_arbiter #(
    .N_REQ  (N_REQ),
    .ID_MSB (ID_MSB)
  ) u_rr_arbiter (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_FLUSH;
      r_flush_cnt     <= '0;
      r_blank_cnt     <= 1'b0;
      r_rr_ptr        <= '0;
      r_gnt           <= '0;
      r_cmp_start     <= 1'b0;
      r_busy          <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_id       <= '0;
      r_resp_found    <= 1'b0;
      r_resp_hash_num <= '0;
      r_cmp_data      <= '0;
    end else begin
      r_gnt       <= '0;
      r_cmp_start <= 1'b0;
      case (r_state)
        // the comparator may still be mid-scan from before reset; let it drain
        ST_FLUSH: begin
          if (r_flush_cnt == FLUSH_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (!cfg_lock && w_any) begin
            r_gnt      <= w_gnt;
            r_cmp_data <= w_req_word[w_idx];
            r_resp_id  <= w_idx;
            r_rr_ptr   <= (w_idx == LAST_ID) ? '0 : w_idx + 1'b1;
            r_busy     <= 1'b1;
            if (hash_count == '0) begin
              r_resp_found    <= 1'b0;
              r_resp_hash_num <= '0;
              r_state         <= ST_RESP;
            end else begin
              r_state <= ST_START;
            end
          end
        end
        ST_START: begin
          r_cmp_start <= 1'b1;
          r_blank_cnt <= 1'b0;
          r_state     <= ST_BLANK;
        end
        // comparator flags still reflect the previous scan here
        ST_BLANK: begin
          if (r_blank_cnt) begin
            r_state <= ST_WAIT;
          end else begin
            r_blank_cnt <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cmp_found) begin
            r_resp_found    <= 1'b1;
            r_resp_hash_num <= cmp_hash_num;
            r_resp_valid    <= 1'b1;
            r_state         <= ST_RESP;
          end else if (cmp_finished) begin
            r_resp_found    <= 1'b0;
            r_resp_hash_num <= '0;
            r_resp_valid    <= 1'b1;
            r_state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_FLUSH;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign gnt           = r_gnt;
  assign cmp_data      = r_cmp_data;
  assign cmp_start     = r_cmp_start;
  assign busy          = r_busy;
  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_resp_id;
  assign resp_found    = r_resp_found;
  assign resp_hash_num = r_resp_hash_num;

endmodule

// File: tb/tb_cmp_scheduler.sv
// Directed bench for cmp_scheduler; the comparator side is driven by hand with exact flag timing.
module tb_cmp_scheduler;

  localparam int N_REQ = 4;
  localparam int FLUSH = 12;

  logic         CLK;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic         cfg_lock;
  logic [3:0]   hash_count;
  logic [31:0]  cmp_data;
  logic         cmp_start;
  logic         cmp_found;
  logic         cmp_finished;
  logic [2:0]   cmp_hash_num;
  logic         busy;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic         resp_found;
  logic [2:0]   resp_hash_num;

  int n_chk  = 0;
  int n_pass = 0;

  cmp_scheduler #(
    .N_REQ        (N_REQ),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .cfg_lock      (cfg_lock),
    .hash_count    (hash_count),
    .cmp_data      (cmp_data),
    .cmp_start     (cmp_start),
    .cmp_found     (cmp_found),
    .cmp_finished  (cmp_finished),
    .cmp_hash_num  (cmp_hash_num),
    .busy          (busy),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_found    (resp_found),
    .resp_hash_num (resp_hash_num)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required summary before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic grant_wait(input string tag, input logic [3:0] exp, output int n);
    n = 0;
    while (gnt == 4'b0 && n < 40) begin
      step();
      n++;
    end
    chk(tag, {28'b0, gnt}, {28'b0, exp});
  endtask

  // called just after reset release with req[0] held
  task automatic flush_then_grant(input string tag);
    int early;
    early = 0;
    repeat (FLUSH) begin
      step();
      if (gnt != 4'b0 || resp_valid) early++;
    end
    chk({tag, "_quiet"}, early, 0);
    step();
    chk({tag, "_gnt"}, {28'b0, gnt}, 32'h1);
  endtask

  // called with cmp_start visible; stale flags are held through the blanking window
  task automatic do_scan(input logic f, input logic fin, input logic [2:0] hn);
    int early;
    early = 0;
    cmp_found    = 1'b1;
    cmp_finished = 1'b1;
    cmp_hash_num = 3'd7;
    repeat (2) begin
      step();
      if (resp_valid) early++;
    end
    chk("blank_ignore", early, 0);
    cmp_found    = f;
    cmp_finished = fin;
    cmp_hash_num = hn;
    step();
    cmp_found    = 1'b0;
    cmp_finished = 1'b0;
    cmp_hash_num = 3'd0;
  endtask

  initial begin
    int n;
    int n2;
    int bad;
    int cs_seen;
    rst_n        = 1'b0;
    req          = 4'b0;
    req_data     = {32'hD3D3_0003, 32'hB0B0_0002, 32'hC1C1_0001, 32'hA0A0_0000};
    cfg_lock     = 1'b0;
    hash_count   = 4'd3;
    cmp_found    = 1'b0;
    cmp_finished = 1'b0;
    cmp_hash_num = 3'd0;
    resp_ready   = 1'b1;
    repeat (2) step();
    chk("rst_busy", {31'b0, busy}, 32'h1);
    chk("rst_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_gnt", {28'b0, gnt}, 32'h0);
    chk("rst_cmp_data", cmp_data, 32'h0);

    // flush, then first grant to requester 0; data absent
    req   = 4'b0001;
    rst_n = 1'b1;
    flush_then_grant("flush");
    req = 4'b0;
    step();
    chk("start_after_gnt", {31'b0, cmp_start}, 32'h1);
    chk("gnt_one_cycle", {28'b0, gnt}, 32'h0);
    do_scan(1'b0, 1'b1, 3'd0);
    chk("t1_valid", {31'b0, resp_valid}, 32'h1);
    chk("t1_found", {31'b0, resp_found}, 32'h0);
    chk("t1_id", {30'b0, resp_id}, 32'h0);
    step();
    chk("t1_done_valid", {31'b0, resp_valid}, 32'h0);
    chk("t1_idle_busy", {31'b0, busy}, 32'h0);

    // requester 2 carries entry 1 of the list
    req = 4'b0100;
    grant_wait("t2_gnt", 4'b0100, n);
    req = 4'b0;
    chk("t2_cmp_data", cmp_data, 32'hB0B0_0002);
    step();
    chk("t2_start", {31'b0, cmp_start}, 32'h1);
    do_scan(1'b1, 1'b0, 3'd1);
    chk("t2_valid", {31'b0, resp_valid}, 32'h1);
    chk("t2_found", {31'b0, resp_found}, 32'h1);
    chk("t2_hash", {29'b0, resp_hash_num}, 32'h1);
    chk("t2_id", {30'b0, resp_id}, 32'h2);
    step();

    // empty list: result one cycle after grant, no start pulse
    hash_count = 4'd0;
    req        = 4'b1000;
    grant_wait("empty_gnt", 4'b1000, n);
    req     = 4'b0;
    cs_seen = int'(cmp_start);
    step();
    cs_seen += int'(cmp_start);
    chk("empty_valid", {31'b0, resp_valid}, 32'h1);
    chk("empty_found", {31'b0, resp_found}, 32'h0);
    chk("empty_hash", {29'b0, resp_hash_num}, 32'h0);
    chk("empty_id", {30'b0, resp_id}, 32'h3);
    step();
    cs_seen += int'(cmp_start);
    chk("empty_no_start", cs_seen, 0);

    // absent data, requester 3 again
    hash_count = 4'd3;
    req        = 4'b1000;
    grant_wait("t3_gnt", 4'b1000, n);
    req = 4'b0;
    step();
    do_scan(1'b0, 1'b1, 3'd0);
    chk("t3_valid", {31'b0, resp_valid}, 32'h1);
    chk("t3_found", {31'b0, resp_found}, 32'h0);
    step();

    // all requesters held: rotation 0,1,2,3,0, then back-pressure on the last
    hash_count = 4'd0;
    req        = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      grant_wait("rr_gnt", 4'(1 << (k % 4)), n);
      if (k == 4) resp_ready = 1'b0;
      step();
    end
    bad = 0;
    repeat (5) begin
      step();
      if (resp_valid !== 1'b1 || resp_id != 2'd0 || resp_found != 1'b0 ||
          resp_hash_num != 3'd0 || gnt != 4'b0) bad++;
    end
    chk("hold_stable", bad, 0);
    resp_ready = 1'b1;
    req        = 4'b0;
    step();
    chk("hold_release", {31'b0, resp_valid}, 32'h0);

    // match on the last entry: found and finished together
    hash_count = 4'd5;
    req        = 4'b0100;
    grant_wait("t5_gnt", 4'b0100, n);
    req = 4'b0;
    step();
    do_scan(1'b1, 1'b1, 3'd4);
    chk("t5_found", {31'b0, resp_found}, 32'h1);
    chk("t5_hash", {29'b0, resp_hash_num}, 32'h4);
    chk("t5_id", {30'b0, resp_id}, 32'h2);
    step();

    // 1-entry list, immediate result: grant-to-grant spacing
    hash_count = 4'd1;
    req        = 4'b0001;
    grant_wait("sp_gnt", 4'b0001, n);
    step();
    do_scan(1'b1, 1'b0, 3'd0);
    grant_wait("sp_gnt2", 4'b0001, n2);
    chk("spacing", 4 + n2, 6);
    req = 4'b0;
    step();
    do_scan(1'b0, 1'b1, 3'd0);
    step();

    // cfg_lock raised mid-compare: result still delivered, grants held off
    hash_count = 4'd3;
    req        = 4'b0010;
    grant_wait("lk_gnt", 4'b0010, n);
    req = 4'b0100;
    repeat (3) step();
    cfg_lock = 1'b1;
    step();
    chk("lk_wait", {31'b0, resp_valid}, 32'h0);
    cmp_finished = 1'b1;
    step();
    cmp_finished = 1'b0;
    chk("lk_valid", {31'b0, resp_valid}, 32'h1);
    chk("lk_id", {30'b0, resp_id}, 32'h1);
    bad = 0;
    repeat (5) begin
      step();
      if (gnt != 4'b0) bad++;
    end
    chk("lk_no_gnt", bad, 0);
    chk("lk_idle", {31'b0, busy}, 32'h0);
    cfg_lock = 1'b0;
    grant_wait("unlk_gnt", 4'b0100, n);
    chk("unlk_latency", n, 1);
    req = 4'b0;
    repeat (3) step();

    // asynchronous reset while waiting on the comparator
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", {28'b0, gnt}, 32'h0);
    chk("ar_start", {31'b0, cmp_start}, 32'h0);
    chk("ar_busy", {31'b0, busy}, 32'h1);
    chk("ar_valid", {31'b0, resp_valid}, 32'h0);
    chk("ar_id", {30'b0, resp_id}, 32'h0);
    chk("ar_cmp_data", cmp_data, 32'h0);
    step();
    cmp_found    = 1'b1;
    cmp_finished = 1'b1;
    req          = 4'b0001;
    rst_n        = 1'b1;
    flush_then_grant("reflush");
    req          = 4'b0;
    cmp_found    = 1'b0;
    cmp_finished = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cmp_scheduler.md
# cmp_scheduler

Shares one `comparator` instance among `N_REQ` requesters (bcrypt core result paths) with round-robin arbitration. Issues one comparison at a time and holds `cmp_data` stable for the whole list scan. Filters the comparator's stale `found`/`finished` flags and returns a tagged result through a valid/ready handshake. Sits between the cores' result outputs and the comparator; also gates new comparisons while `cmp_config` rewrites the hash list.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `ID_MSB`, default `$clog2(N_REQ)-1`: requester index MSB.
- `FLUSH_CYCLES`, default `` `NUM_HASHES+4 ``: post-reset wait for a comparator that may still be scanning.
- `CLK` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in N_REQ: per-requester comparison request; level, held until `gnt`.
- `req_data` in N_REQ*32: requester i's word at [32i+31:32i].
- `gnt` out N_REQ: one-hot, single-cycle acceptance pulse.
- `cfg_lock` in 1: hash list being rewritten; no new grants while high.
- `hash_count` in `` `HASH_COUNT_MSB+1 ``: current list size, same value given to the comparator.
- `cmp_data` out 32: to comparator.
- `cmp_start` out 1: to comparator `start`.
- `cmp_found`, `cmp_finished` in 1: from comparator.
- `cmp_hash_num` in `` `HASH_NUM_MSB+1 ``: from comparator.
- `busy` out 1: comparator owned (all states except IDLE).
- `resp_valid` out 1; `resp_ready` in 1: result handshake.
- `resp_id` out ID_MSB+1; `resp_found` out 1; `resp_hash_num` out `` `HASH_NUM_MSB+1 ``.

## Operation
- FSM states: FLUSH, IDLE, START, BLANK, WAIT, RESP.
- FLUSH:
  - entered on reset;
  - counts `FLUSH_CYCLES`, then goes to IDLE.
- IDLE:
  - if `!cfg_lock` and any `req`, grant the first asserted requester at or after `rr_ptr` (wrapping);
  - latch `req_data` into `cmp_data` and the index into `resp_id`;
  - pulse `gnt`, set `rr_ptr` to index+1 mod N_REQ.
  - If `hash_count==0`: go directly to RESP with `resp_found=0`, `resp_hash_num=0`, no `cmp_start`.
  - Otherwise go to START.
- START: `cmp_start=1` for exactly one cycle, then BLANK.
- BLANK:
  - lasts 2 cycles;
  - comparator flags still hold the previous result and are ignored;
  - then WAIT.
- WAIT:
  - on `cmp_found`: latch `resp_found=1`, `resp_hash_num=cmp_hash_num`, go to RESP;
  - else on `cmp_finished`: latch `resp_found=0`, `resp_hash_num=0`, go to RESP.
  - If both are high in the same cycle, found wins.
- RESP:
  - `resp_valid=1`; outputs held constant until `resp_ready`;
  - on the handshake cycle go to IDLE.
- `cmp_data` is held unchanged from grant until leaving RESP.
- `cfg_lock` affects IDLE only; assertion mid-compare does not abort.
- Width rules:
  - `rr_ptr` wraps modulo N_REQ (non-power-of-2 N_REQ supported);
  - FLUSH counter sized `$clog2(FLUSH_CYCLES+1)`.

## Timing
- Reset values:
  - state FLUSH, `gnt=0`, `cmp_start=0`, `busy=1`;
  - `resp_valid=0`, `resp_id=0`, `resp_found=0`, `resp_hash_num=0`;
  - `cmp_data=0`, `rr_ptr=0`.
- Reset deassertion mid-compare: FLUSH absorbs the remaining comparator scan; no `resp_valid` until a new grant.
- All outputs registered.
- Grant latency: `gnt` rises 1 cycle after `req` seen in IDLE.
- `cmp_start` is 1 cycle after `gnt`.
- First sampled flag is 3 cycles after `cmp_start`.
- Empty-list path: `resp_valid` is 1 cycle after `gnt`.
- Back-to-back: a new grant is possible the cycle after the `resp_valid && resp_ready` handshake.
- Minimum request-to-request spacing is 6 cycles with a 1-entry list.

## Structure
- Shared package / `main.vh`: `NUM_HASHES`, `HASH_NUM_MSB`, `HASH_COUNT_MSB`, and the FSM state encodings as localparams.
- One sub-module: `rr_arbiter` (N_REQ-wide round-robin pick returning one-hot plus index from `req` and `rr_ptr`, combinational).

## Test plan
- Reset, `req[0]=1` at cycle 0 → no `gnt` before FLUSH_CYCLES elapse; then `gnt=0001`, `cmp_start` one cycle later.
- `hash_count=3`, list {A,B,C}, `req_data[2]=B` → `resp_found=1`, `resp_hash_num=1`, `resp_id=2`. Stale `found` held high from the prior compare during BLANK is ignored.
- `hash_count=3`, data absent → `resp_found=0` after `cmp_finished`. Then `hash_count=0` → `resp_valid` 1 cycle after `gnt`, `cmp_start` never pulses.
- All 4 `req` held high continuously → grants 0,1,2,3,0 in order. `resp_ready` low for 5 cycles → `resp_*` stable, no new `gnt`.
- Match on the last entry (found and finished same cycle) → `resp_found=1`, `resp_hash_num=hash_count-1`.
- `cfg_lock` raised during WAIT → current result delivered, no further `gnt` until `cfg_lock` drops. `rst_n` pulsed low in WAIT → all outputs at reset values immediately, FLUSH restarts.
